pipe_ctrl_unit: RTL and testbench

Parametrised pipelined controller for the 5-stage MIPS core. It decodes the D-stage instruction and carries control through the D/E/M/W pipeline registers. It also integrates hazard handling: load-use stall, branch/jump flush, external memory stall, and E-stage forwarding selects. It sits between the instruction memory output and the datapath, and replaces the fixed-width, stall-less controller.

---
 rtl/pipe_ctrl_unit.sv | 238 +++++++++++++++++++++++
 tb/tb_pipe_ctrl_unit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control for the 5-stage MIPS core: D-stage decode, D/E/M/W control registers and hazard unit.
// Build option: define PIPE_CTRL_FWD_EN for E-stage forwarding; otherwise dependent instructions stall in D.
module pipe_ctrl_unit #(
    parameter int ALUCTRL_W  = 4,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           instrF,
    input  logic                  zeroM,
    input  logic                  ext_stall,
    input  logic [REG_ADDR_W-1:0] rsE,
    input  logic [REG_ADDR_W-1:0] rtE,
    input  logic [REG_ADDR_W-1:0] writeregE,
    input  logic [REG_ADDR_W-1:0] writeregM,
    input  logic [REG_ADDR_W-1:0] writeregW,
    output logic [31:0]           instrD,
    output logic                  branchD,
    output logic                  jumpD,
    output logic                  alusrcE,
    output logic                  regdstE,
    output logic [ALUCTRL_W-1:0]  alucontrolE,
    output logic                  memwriteM,
    output logic                  regwriteM,
    output logic                  pcsrcM,
    output logic                  memtoregW,
    output logic                  regwriteW,
    output logic                  stallF,
    output logic                  stallD,
    output logic                  flushE,
    output logic [1:0]            forwardAE,
    output logic [1:0]            forwardBE
);

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_NOR = 3'b100;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    logic [5:0] opD;
    logic [5:0] functD;
    logic       regWriteD, regDstD, aluSrcD, memWriteD, memToRegD;
    logic [2:0] aluCodeD;

    logic       regWriteE, memToRegE, memWriteE, branchE;
    logic [2:0] aluCodeE;
    logic       memToRegM, branchM;

    logic [REG_ADDR_W-1:0] rsD;
    logic [REG_ADDR_W-1:0] rtD;
    logic                  lwStall;

    assign opD    = instrD[31:26];
    assign functD = instrD[5:0];
    assign rsD    = REG_ADDR_W'(instrD[25:21]);
    assign rtD    = REG_ADDR_W'(instrD[20:16]);

    always_comb begin
        regWriteD = 1'b0;
        regDstD   = 1'b0;
        aluSrcD   = 1'b0;
        branchD   = 1'b0;
        memWriteD = 1'b0;
        memToRegD = 1'b0;
        jumpD     = 1'b0;
        aluCodeD  = ALU_AND;
        case (opD)
            6'b000000: begin
                regWriteD = 1'b1;
                regDstD   = 1'b1;
                case (functD)
                    6'b100000: aluCodeD = ALU_ADD;
                    6'b100010: aluCodeD = ALU_SUB;
                    6'b100100: aluCodeD = ALU_AND;
                    6'b100101: aluCodeD = ALU_OR;
                    6'b100110: aluCodeD = ALU_XOR;
                    6'b100111: aluCodeD = ALU_NOR;
                    6'b101010: aluCodeD = ALU_SLT;
                    default: begin
                        // unknown funct becomes a harmless NOP
                        regWriteD = 1'b0;
                        regDstD   = 1'b0;
                        aluCodeD  = ALU_ADD;
                    end
                endcase
            end
            6'b100011: begin
                regWriteD = 1'b1;
                aluSrcD   = 1'b1;
                memToRegD = 1'b1;
                aluCodeD  = ALU_ADD;
            end
            6'b101011: begin
                aluSrcD   = 1'b1;
                memWriteD = 1'b1;
                aluCodeD  = ALU_ADD;
            end
            6'b000100: begin
                branchD  = 1'b1;
                aluCodeD = ALU_SUB;
            end
            6'b001000: begin
                regWriteD = 1'b1;
                aluSrcD   = 1'b1;
                aluCodeD  = ALU_ADD;
            end
            6'b001100: begin
                regWriteD = 1'b1;
                aluSrcD   = 1'b1;
                aluCodeD  = ALU_AND;
            end
            6'b001101: begin
                regWriteD = 1'b1;
                aluSrcD   = 1'b1;
                aluCodeD  = ALU_OR;
            end
            6'b001010: begin
                regWriteD = 1'b1;
                aluSrcD   = 1'b1;
                aluCodeD  = ALU_SLT;
            end
            6'b000010: jumpD = 1'b1;
            default: ;
        endcase
    end

    assign pcsrcM      = branchM & zeroM;
    assign alucontrolE = ALUCTRL_W'(aluCodeE);

    assign lwStall = memToRegE & regWriteE & (writeregE != '0) &
                     ((writeregE == rsD) | (writeregE == rtD));

`ifdef PIPE_CTRL_FWD_EN
    function automatic logic [1:0] fwdSel(input logic [REG_ADDR_W-1:0] src,
                                          input logic rwM, input logic [REG_ADDR_W-1:0] dstM,
                                          input logic rwW, input logic [REG_ADDR_W-1:0] dstW);
        if (rwM && (dstM != '0) && (dstM == src))
            return 2'b10;
        else if (rwW && (dstW != '0) && (dstW == src))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign forwardAE = fwdSel(rsE, regwriteM, writeregM, regwriteW, writeregW);
    assign forwardBE = fwdSel(rtE, regwriteM, writeregM, regwriteW, writeregW);
    assign stallD    = lwStall;
`else
    logic hitE, hitM, unusedFwdIn;

    // without bypass paths, any in-flight E/M producer blocks D; W relies on write-first regfile
    assign hitE = regWriteE & (writeregE != '0) & ((writeregE == rsD) | (writeregE == rtD));
    assign hitM = regwriteM & (writeregM != '0) & ((writeregM == rsD) | (writeregM == rtD));
    assign stallD      = lwStall | hitE | hitM;
    assign forwardAE   = 2'b00;
    assign forwardBE   = 2'b00;
    assign unusedFwdIn = ^{rsE, rtE, writeregW};
`endif

    assign stallF = stallD;
    assign flushE = stallD | pcsrcM;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instrD <= '0;
        end else if (!ext_stall) begin
            if (pcsrcM || jumpD)
                instrD <= '0;
            else if (!stallD)
                instrD <= instrF;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regWriteE <= 1'b0;
            memToRegE <= 1'b0;
            memWriteE <= 1'b0;
            branchE   <= 1'b0;
            alusrcE   <= 1'b0;
            regdstE   <= 1'b0;
            aluCodeE  <= '0;
        end else if (!ext_stall) begin
            if (flushE) begin
                regWriteE <= 1'b0;
                memToRegE <= 1'b0;
                memWriteE <= 1'b0;
                branchE   <= 1'b0;
                alusrcE   <= 1'b0;
                regdstE   <= 1'b0;
                aluCodeE  <= '0;
            end else begin
                regWriteE <= regWriteD;
                memToRegE <= memToRegD;
                memWriteE <= memWriteD;
                branchE   <= branchD;
                alusrcE   <= aluSrcD;
                regdstE   <= regDstD;
                aluCodeE  <= aluCodeD;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regwriteM <= 1'b0;
            memToRegM <= 1'b0;
            memwriteM <= 1'b0;
            branchM   <= 1'b0;
        end else if (!ext_stall) begin
            if (pcsrcM) begin
                regwriteM <= 1'b0;
                memToRegM <= 1'b0;
                memwriteM <= 1'b0;
                branchM   <= 1'b0;
            end else begin
                regwriteM <= regWriteE;
                memToRegM <= memToRegE;
                memwriteM <= memWriteE;
                branchM   <= branchE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regwriteW <= 1'b0;
            memtoregW <= 1'b0;
        end else if (!ext_stall) begin
            regwriteW <= regwriteM;
            memtoregW <= memToRegM;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: decode table walked through all stages, then hazard sequences.
module tb_pipe_ctrl_unit;

    localparam int AW = 4;
    localparam int RW = 5;
`ifdef PIPE_CTRL_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    localparam logic [31:0] I_LW   = 32'h8C28_0000;  // lw  $8,0($1)
    localparam logic [31:0] I_ADD  = 32'h0108_4820;  // add $9,$8,$8
    localparam logic [31:0] I_ADD3 = 32'h0022_1820;  // add $3,$1,$2
    localparam logic [31:0] I_BEQ  = 32'h1000_0000;
    localparam logic [31:0] I_SW   = 32'hAC00_0000;
    localparam logic [31:0] I_ADDI = 32'h2000_0000;
    localparam logic [31:0] I_ORI  = 32'h3400_0000;
    localparam logic [31:0] I_J    = 32'h0800_0000;

    logic            clk = 1'b0;
    logic            rst;
    logic [31:0]     instrF;
    logic            zeroM, ext_stall;
    logic [RW-1:0]   rsE, rtE, writeregE, writeregM, writeregW;
    logic [31:0]     instrD;
    logic            branchD, jumpD, alusrcE, regdstE;
    logic [AW-1:0]   alucontrolE;
    logic            memwriteM, regwriteM, pcsrcM, memtoregW, regwriteW;
    logic            stallF, stallD, flushE;
    logic [1:0]      forwardAE, forwardBE;

    pipe_ctrl_unit #(.ALUCTRL_W(AW), .REG_ADDR_W(RW)) dut (
        .clk(clk), .rst(rst), .instrF(instrF), .zeroM(zeroM), .ext_stall(ext_stall),
        .rsE(rsE), .rtE(rtE), .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .instrD(instrD), .branchD(branchD), .jumpD(jumpD), .alusrcE(alusrcE), .regdstE(regdstE),
        .alucontrolE(alucontrolE), .memwriteM(memwriteM), .regwriteM(regwriteM), .pcsrcM(pcsrcM),
        .memtoregW(memtoregW), .regwriteW(regwriteW), .stallF(stallF), .stallD(stallD),
        .flushE(flushE), .forwardAE(forwardAE), .forwardBE(forwardBE)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic        br;
        logic        jmp;
        logic        aluSrc;
        logic        regDst;
        logic [3:0]  alu;
        logic        memWr;
        logic        regWr;
        logic        memToReg;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    int passCnt  = 0;
    int totalCnt = 0;

    function automatic vec_t mk(input logic [31:0] i, input logic br, input logic jmp,
                                input logic src, input logic dst, input logic [3:0] alu,
                                input logic mw, input logic rw, input logic m2r);
        vec_t v;
        v.instr = i; v.br = br; v.jmp = jmp; v.aluSrc = src; v.regDst = dst;
        v.alu = alu; v.memWr = mw; v.regWr = rw; v.memToReg = m2r;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        zeroM = 1'b0; ext_stall = 1'b0;
        rsE = '0; rtE = '0; writeregE = '0; writeregM = '0; writeregW = '0;
        rst = 1'b0;
        #2;
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mk(32'h0000_0020, 0, 0, 0, 1, 4'b0010, 0, 1, 0);  // add
        vecs[1]  = mk(32'h0000_0022, 0, 0, 0, 1, 4'b0110, 0, 1, 0);  // sub
        vecs[2]  = mk(32'h0000_0024, 0, 0, 0, 1, 4'b0000, 0, 1, 0);  // and
        vecs[3]  = mk(32'h0000_0025, 0, 0, 0, 1, 4'b0001, 0, 1, 0);  // or
        vecs[4]  = mk(32'h0000_0026, 0, 0, 0, 1, 4'b0011, 0, 1, 0);  // xor
        vecs[5]  = mk(32'h0000_0027, 0, 0, 0, 1, 4'b0100, 0, 1, 0);  // nor
        vecs[6]  = mk(32'h0000_002A, 0, 0, 0, 1, 4'b0111, 0, 1, 0);  // slt
        vecs[7]  = mk(32'h0000_003F, 0, 0, 0, 0, 4'b0010, 0, 0, 0);  // bad funct
        vecs[8]  = mk(32'h8C00_0000, 0, 0, 1, 0, 4'b0010, 0, 1, 1);  // lw
        vecs[9]  = mk(32'hAC00_0000, 0, 0, 1, 0, 4'b0010, 1, 0, 0);  // sw
        vecs[10] = mk(32'h1000_0000, 1, 0, 0, 0, 4'b0110, 0, 0, 0);  // beq
        vecs[11] = mk(32'h2000_0000, 0, 0, 1, 0, 4'b0010, 0, 1, 0);  // addi
        vecs[12] = mk(32'h3000_0000, 0, 0, 1, 0, 4'b0000, 0, 1, 0);  // andi
        vecs[13] = mk(32'h3400_0000, 0, 0, 1, 0, 4'b0001, 0, 1, 0);  // ori
        vecs[14] = mk(32'h2800_0000, 0, 0, 1, 0, 4'b0111, 0, 1, 0);  // slti
        vecs[15] = mk(32'h0800_0000, 0, 1, 0, 0, 4'b0000, 0, 0, 0);  // j
        vecs[16] = mk(32'hFC00_0000, 0, 0, 0, 0, 4'b0000, 0, 0, 0);  // bad op

        // reset holds everything at zero even with clock edges and a live instruction
        instrF = I_ADD3;
        zeroM = 1'b0; ext_stall = 1'b0;
        rsE = '0; rtE = '0; writeregE = '0; writeregM = '0; writeregW = '0;
        rst = 1'b0;
        tick();
        tick();
        chk("rst.instrD", instrD, 32'h0);
        chk("rst.outs", {12'h0, branchD, jumpD, alusrcE, regdstE, alucontrolE, memwriteM, regwriteM,
                         pcsrcM, memtoregW, regwriteW, stallF, stallD, flushE, forwardAE, forwardBE}, 32'h0);
        rst = 1'b1;
        tick();
        chk("rel.e1.instrD", instrD, I_ADD3);
        chk("rel.e1.regwriteM", {31'h0, regwriteM}, 32'h0);
        tick();
        chk("rel.e2.alucontrolE", {28'h0, alucontrolE}, 32'h2);
        chk("rel.e2.regdstE", {31'h0, regdstE}, 32'h1);
        tick();
        chk("rel.e3.regwriteM", {31'h0, regwriteM}, 32'h1);
        chk("rel.e3.regwriteW", {31'h0, regwriteW}, 32'h0);
        tick();
        chk("rel.e4.regwriteW", {31'h0, regwriteW}, 32'h1);

        // asynchronous mid-flight reset clears without waiting for an edge
        rst = 1'b0;
        #1;
        chk("midrst", {instrD[15:0], regwriteM, regwriteW, regdstE, alusrcE}, 20'h0);
        rst = 1'b1;

        for (int i = 0; i < NV; i++) begin
            instrF = vecs[i].instr;
            doReset();
            tick();
            chk($sformatf("v%0d.instrD", i), instrD, vecs[i].instr);
            chk($sformatf("v%0d.brj", i), {30'h0, branchD, jumpD}, {30'h0, vecs[i].br, vecs[i].jmp});
            tick();
            chk($sformatf("v%0d.E", i), {26'h0, alusrcE, regdstE, alucontrolE},
                {26'h0, vecs[i].aluSrc, vecs[i].regDst, vecs[i].alu});
            tick();
            chk($sformatf("v%0d.M", i), {29'h0, memwriteM, regwriteM, pcsrcM},
                {29'h0, vecs[i].memWr, vecs[i].regWr, 1'b0});
            tick();
            chk($sformatf("v%0d.W", i), {30'h0, memtoregW, regwriteW},
                {30'h0, vecs[i].memToReg, vecs[i].regWr});
        end

        // load-use: lw $8 then add $9,$8,$8
        instrF = I_LW;
        doReset();
        tick();
        chk("lu.e1.instrD", instrD, I_LW);
        instrF = I_ADD;
        tick();
        writeregE = 5'd8;
        #1;
        chk("lu.e2.stall", {29'h0, stallF, stallD, flushE}, 32'h7);
        instrF = 32'h0;
        tick();
        chk("lu.e3.instrD", instrD, I_ADD);
        writeregE = 5'd0;
        writeregM = 5'd8;
        #1;
        chk("lu.e3.stall", {29'h0, stallF, stallD, flushE}, FWD ? 32'h0 : 32'h7);
        tick();
        writeregM = 5'd0;
        writeregW = 5'd8;
        rsE = 5'd8;
        rtE = 5'd8;
        #1;
        chk("lu.e4.instrD", instrD, FWD ? 32'h0 : I_ADD);
        chk("lu.e4.stall", {31'h0, stallD}, 32'h0);
        chk("lu.e4.W", {30'h0, regwriteW, memtoregW}, 32'h3);
        chk("lu.e4.fwd", {28'h0, forwardAE, forwardBE}, FWD ? 32'h5 : 32'h0);

        // forward priority with both M and W writing
        instrF = I_ADDI;
        doReset();
        for (int k = 0; k < 4; k++) tick();
        writeregM = 5'd3; writeregW = 5'd3; rsE = 5'd3; rtE = 5'd5;
        #1;
        chk("fp.mw", {28'h0, forwardAE, forwardBE}, FWD ? 32'h8 : 32'h0);
        writeregW = 5'd5;
        #1;
        chk("fp.split", {28'h0, forwardAE, forwardBE}, FWD ? 32'h9 : 32'h0);
        writeregM = 5'd7; writeregW = 5'd3;
        #1;
        chk("fp.wonly", {28'h0, forwardAE, forwardBE}, FWD ? 32'h4 : 32'h0);
        writeregM = 5'd0; writeregW = 5'd0; rsE = 5'd0; rtE = 5'd0;
        #1;
        chk("fp.zero", {28'h0, forwardAE, forwardBE}, 32'h0);

        // taken branch flushes D, E and M together
        instrF = I_BEQ;
        doReset();
        tick();
        instrF = I_SW;
        tick();
        instrF = I_ADDI;
        tick();
        zeroM = 1'b1;
        instrF = I_ORI;
        #1;
        chk("br.pcsrc", {30'h0, pcsrcM, flushE}, 32'h3);
        tick();
        zeroM = 1'b0;
        chk("br.instrD", instrD, 32'h0);
        chk("br.flushed", {29'h0, memwriteM, alusrcE, pcsrcM}, 32'h0);

        // jump clears F/D after one edge
        instrF = I_J;
        doReset();
        tick();
        chk("j.jumpD", {31'h0, jumpD}, 32'h1);
        instrF = I_ADDI;
        tick();
        chk("j.instrD", instrD, 32'h0);

        // ext_stall freezes a taken branch; flush lands after release
        instrF = I_BEQ;
        doReset();
        tick();
        instrF = I_SW;
        tick();
        instrF = I_ADDI;
        tick();
        zeroM = 1'b1;
        ext_stall = 1'b1;
        instrF = I_ORI;
        #1;
        chk("es.pcsrc0", {31'h0, pcsrcM}, 32'h1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("es.hold%0d.instrD", k), instrD, I_ADDI);
            chk($sformatf("es.hold%0d.ctl", k), {30'h0, pcsrcM, alusrcE}, 32'h3);
        end
        ext_stall = 1'b0;
        tick();
        zeroM = 1'b0;
        chk("es.rel.instrD", instrD, 32'h0);
        chk("es.rel.ctl", {29'h0, memwriteM, alusrcE, pcsrcM}, 32'h0);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
